// File: rtl/tcam_prog_pkg.sv
// Shared types for the TCAM programming scheduler: op codes, sequencer states,
// requester source encoding and the per-op state-walk helpers.
package tcam_prog_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_DEL     = 2'b01,
        OP_SETDEF  = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE, VINV, MASK, ACT, VAL, DMASK, DEF, DONE
    } state_e;

    localparam logic SRC_HOST  = 1'b0;
    localparam logic SRC_LEARN = 1'b1;

    // First state entered when a command is accepted.
    function automatic state_e first_state(op_e op);
        case (op)
            OP_ADD, OP_DEL: return VINV;
            OP_SETDEF:      return DEF;
            default:        return DONE;
        endcase
    endfunction

    // Successor of a write state once its write has been issued.
    function automatic state_e next_state(state_e s, op_e op);
        case (s)
            VINV:            return (op == OP_ADD) ? MASK : DMASK;
            MASK:            return ACT;
            ACT:             return VAL;
            VAL, DMASK, DEF: return DONE;
            default:         return IDLE;
        endcase
    endfunction

    function automatic logic is_write(state_e s);
        return s inside {VINV, MASK, ACT, VAL, DMASK, DEF};
    endfunction

endpackage

// File: rtl/tcam_prog_sched_if.sv
// Rule-command request channel: one instance per requester (host CSR, learn engine).
interface tcam_prog_sched_if #(
    parameter int AW       = 4,
    parameter int KEY_W    = 128,
    parameter int ACTION_W = 64
);
    logic                valid;
    logic                ready;
    logic [1:0]          op;
    logic [AW-1:0]       addr;
    logic [KEY_W-1:0]    key;
    logic [KEY_W-1:0]    mask;
    logic [ACTION_W-1:0] action;

    modport master (output valid, op, addr, key, mask, action, input ready);
    modport slave  (input valid, op, addr, key, mask, action, output ready);
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 = host, bit 1 = learn.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic rr_last;  // 1: learn was granted last

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset to "learn last" so the host wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rr_last <= 1'b1;
        else if (accept) rr_last <= grant[1];
    end
endmodule

// File: rtl/tcam_prog_sched.sv
// Arbitrates host/learn rule commands and expands each into ordered single-cycle
// TCAM/action write pulses. Optional lookup quiescing: define TCAM_PROG_QUIESCE_EN.
module tcam_prog_sched
    import tcam_prog_pkg::*;
#(
    parameter int               TCAM_ENTRIES = 16,
    parameter int               KEY_W        = 128,
    parameter int               ACTION_W     = 64,
    parameter logic [KEY_W-1:0] DEL_PATTERN  = {KEY_W{1'b1}},
    parameter int               QUIESCE_MAX  = 32,
    localparam int              AW           = $clog2(TCAM_ENTRIES)
) (
    input  logic                clk,
    input  logic                rst_n,
    tcam_prog_sched_if.slave    h_req,
    tcam_prog_sched_if.slave    l_req,
    input  logic                lookup_active,
    output logic                tcam_wr_en,
    output logic                tcam_wr_is_mask,
    output logic [AW-1:0]       tcam_wr_addr,
    output logic [KEY_W-1:0]    tcam_wr_data,
    output logic                action_wr_en,
    output logic [AW-1:0]       action_wr_addr,
    output logic [ACTION_W-1:0] action_wr_data,
    output logic                action_wr_default,
    output logic [ACTION_W-1:0] action_default_data,
    output logic                done_valid,
    output logic                done_src,
    output logic                done_err,
    output logic                busy
);

    typedef struct packed {
        logic                tcam_en;
        logic                is_mask;
        logic [AW-1:0]       tcam_addr;
        logic [KEY_W-1:0]    tcam_data;
        logic                act_en;
        logic [AW-1:0]       act_addr;
        logic [ACTION_W-1:0] act_data;
        logic                act_def;
        logic [ACTION_W-1:0] def_data;
    } wr_t;

    // Write pulse owned by each write state; fields not used by the state stay zero.
    function automatic wr_t wr_for(state_e s, logic [AW-1:0] addr, logic [KEY_W-1:0] key,
                                   logic [KEY_W-1:0] mask, logic [ACTION_W-1:0] action);
        wr_t w;
        w = '0;
        case (s)
            VINV:  begin w.tcam_en = 1'b1; w.tcam_addr = addr; w.tcam_data = DEL_PATTERN; end
            MASK:  begin w.tcam_en = 1'b1; w.is_mask = 1'b1; w.tcam_addr = addr; w.tcam_data = mask; end
            ACT:   begin w.act_en = 1'b1; w.act_addr = addr; w.act_data = action; end
            VAL:   begin w.tcam_en = 1'b1; w.tcam_addr = addr; w.tcam_data = key; end
            DMASK: begin w.tcam_en = 1'b1; w.is_mask = 1'b1; w.tcam_addr = addr; w.tcam_data = '1; end
            DEF:   begin w.act_def = 1'b1; w.def_data = action; end
            default: ;
        endcase
        return w;
    endfunction

    state_e              state, first, nxt;
    op_e                 sel_op, lat_op;
    logic                sel_src, lat_src;
    logic [AW-1:0]       sel_addr, lat_addr;
    logic [KEY_W-1:0]    sel_key, sel_mask, lat_key, lat_mask;
    logic [ACTION_W-1:0] sel_action, lat_action;
    logic [1:0]          grant;
    logic                idle, accept;
    wr_t                 wr;
    logic                wr_fired, go_entry, go_stall;

    // NOTE: ready is gated with rst_n so neither requester sees ready while reset is held.
    assign idle        = (state == IDLE) && rst_n;
    assign accept      = idle && (grant != 2'b00);
    assign h_req.ready = idle && grant[0];
    assign l_req.ready = idle && grant[1];

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({l_req.valid, h_req.valid}),
        .accept (accept),
        .grant  (grant)
    );

    assign sel_src    = grant[1];
    assign sel_op     = op_e'(grant[1] ? l_req.op : h_req.op);
    assign sel_addr   = grant[1] ? l_req.addr   : h_req.addr;
    assign sel_key    = grant[1] ? l_req.key    : h_req.key;
    assign sel_mask   = grant[1] ? l_req.mask   : h_req.mask;
    assign sel_action = grant[1] ? l_req.action : h_req.action;

    assign first    = first_state(sel_op);
    assign nxt      = next_state(state, lat_op);
    assign wr_fired = wr.tcam_en || wr.act_en || wr.act_def;

`ifdef TCAM_PROG_QUIESCE_EN
    localparam int CNT_W = $clog2(QUIESCE_MAX + 1);
    logic [CNT_W-1:0] stall_cnt;

    // Counts stalled cycles of the current write state; the write is forced on the
    // edge where the count reaches QUIESCE_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           stall_cnt <= '0;
        else if (!is_write(state) || wr_fired) stall_cnt <= '0;
        else if (stall_cnt != CNT_W'(QUIESCE_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign go_entry = !lookup_active;
    assign go_stall = !lookup_active || (stall_cnt + CNT_W'(1) == CNT_W'(QUIESCE_MAX));
`else
    logic unused_lookup;
    assign unused_lookup = lookup_active;
    assign go_entry      = 1'b1;
    assign go_stall      = 1'b1;
`endif

    // Outputs are registered: the write for a state is loaded on the edge that enters
    // (or un-stalls) it, and the state advances on the edge after the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr         <= '0;
            done_valid <= 1'b0;
            done_src   <= 1'b0;
            done_err   <= 1'b0;
            lat_op     <= OP_ADD;
            lat_src    <= SRC_HOST;
            lat_addr   <= '0;
            lat_key    <= '0;
            lat_mask   <= '0;
            lat_action <= '0;
        end else begin
            wr         <= '0;
            done_valid <= 1'b0;
            done_src   <= 1'b0;
            done_err   <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    lat_op     <= sel_op;
                    lat_src    <= sel_src;
                    lat_addr   <= sel_addr;
                    lat_key    <= sel_key;
                    lat_mask   <= sel_mask;
                    lat_action <= sel_action;
                    state      <= first;
                    if (first == DONE) begin
                        done_valid <= 1'b1;
                        done_src   <= sel_src;
                        done_err   <= 1'b1;
                    end else if (go_entry) begin
                        wr <= wr_for(first, sel_addr, sel_key, sel_mask, sel_action);
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    if (wr_fired) begin
                        state <= nxt;
                        if (nxt == DONE) begin
                            done_valid <= 1'b1;
                            done_src   <= lat_src;
                        end else if (go_entry) begin
                            wr <= wr_for(nxt, lat_addr, lat_key, lat_mask, lat_action);
                        end
                    end else if (go_stall) begin
                        wr <= wr_for(state, lat_addr, lat_key, lat_mask, lat_action);
                    end
                end
            endcase
        end
    end

    assign tcam_wr_en          = wr.tcam_en;
    assign tcam_wr_is_mask     = wr.is_mask;
    assign tcam_wr_addr        = wr.tcam_addr;
    assign tcam_wr_data        = wr.tcam_data;
    assign action_wr_en        = wr.act_en;
    assign action_wr_addr      = wr.act_addr;
    assign action_wr_data      = wr.act_data;
    assign action_wr_default   = wr.act_def;
    assign action_default_data = wr.def_data;
    assign busy                = (state != IDLE);

endmodule

// File: tb/tb_tcam_prog_sched.sv
// Directed self-checking bench for tcam_prog_sched; quiesce cases follow TCAM_PROG_QUIESCE_EN.
module tb_tcam_prog_sched;

    localparam int AW       = 4;
    localparam int KEY_W    = 128;
    localparam int ACTION_W = 64;

    localparam logic [127:0] DEL_PAT = {128{1'b1}};
    localparam logic [127:0] K1 = 128'h0A00_0001_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] M1 = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
    localparam logic [127:0] K2 = 128'h0B00_0002_0000_0000_0000_0000_0000_00AA;
    localparam logic [127:0] M2 = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

    // ctl = {tcam_wr_en, is_mask, action_wr_en, action_wr_default, done_valid, done_src, done_err}
    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_VAL   = 7'b1000000;
    localparam logic [6:0] C_MASK  = 7'b1100000;
    localparam logic [6:0] C_ACT   = 7'b0010000;
    localparam logic [6:0] C_DEF   = 7'b0001000;
    localparam logic [6:0] C_DONEH = 7'b0000100;
    localparam logic [6:0] C_DONEL = 7'b0000110;
    localparam logic [6:0] C_ERRH  = 7'b0000101;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                lookup_active = 1'b0;
    logic                tcam_wr_en, tcam_wr_is_mask, action_wr_en, action_wr_default;
    logic [AW-1:0]       tcam_wr_addr, action_wr_addr;
    logic [KEY_W-1:0]    tcam_wr_data;
    logic [ACTION_W-1:0] action_wr_data, action_default_data;
    logic                done_valid, done_src, done_err, busy;
    logic [6:0]          ctl;

    int n_checks = 0;
    int n_errors = 0;

    tcam_prog_sched_if #(.AW(AW), .KEY_W(KEY_W), .ACTION_W(ACTION_W)) h_if ();
    tcam_prog_sched_if #(.AW(AW), .KEY_W(KEY_W), .ACTION_W(ACTION_W)) l_if ();

    tcam_prog_sched dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .h_req               (h_if),
        .l_req               (l_if),
        .lookup_active       (lookup_active),
        .tcam_wr_en          (tcam_wr_en),
        .tcam_wr_is_mask     (tcam_wr_is_mask),
        .tcam_wr_addr        (tcam_wr_addr),
        .tcam_wr_data        (tcam_wr_data),
        .action_wr_en        (action_wr_en),
        .action_wr_addr      (action_wr_addr),
        .action_wr_data      (action_wr_data),
        .action_wr_default   (action_wr_default),
        .action_default_data (action_default_data),
        .done_valid          (done_valid),
        .done_src            (done_src),
        .done_err            (done_err),
        .busy                (busy)
    );

    assign ctl = {tcam_wr_en, tcam_wr_is_mask, action_wr_en, action_wr_default,
                  done_valid, done_src, done_err};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge and compare the control vector.
    task automatic exp_ctl(input string tag, input logic [6:0] e);
        @(negedge clk);
        check(tag, ctl, e);
    endtask

    // Present a command, wait (bounded) for ready, let it be accepted, then scramble
    // the request fields to show they are not re-sampled. Returns just after the accept edge.
    task automatic send(input logic side, input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [127:0] key, input logic [127:0] mask, input logic [63:0] act);
        int n;
        @(negedge clk);
        if (side) begin
            l_if.valid = 1'b1; l_if.op = op; l_if.addr = addr;
            l_if.key = key; l_if.mask = mask; l_if.action = act;
        end else begin
            h_if.valid = 1'b1; h_if.op = op; h_if.addr = addr;
            h_if.key = key; h_if.mask = mask; h_if.action = act;
        end
        #1;
        n = 0;
        while (!(side ? l_if.ready : h_if.ready) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("send_ready", side ? l_if.ready : h_if.ready, 1'b1);
        @(posedge clk);
        #1;
        h_if.valid = 1'b0; l_if.valid = 1'b0;
        h_if.key = ~h_if.key; h_if.mask = ~h_if.mask; h_if.action = ~h_if.action; h_if.addr = ~h_if.addr;
        l_if.key = ~l_if.key; l_if.mask = ~l_if.mask; l_if.action = ~l_if.action; l_if.addr = ~l_if.addr;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        h_if.valid = 1'b1; h_if.op = 2'b11; h_if.addr = '0;
        h_if.key = '0; h_if.mask = '0; h_if.action = '0;
        l_if.valid = 1'b0; l_if.op = 2'b00; l_if.addr = '0;
        l_if.key = '0; l_if.mask = '0; l_if.action = '0;

        // Reset: outputs zero and no ready even with a valid request pending.
        repeat (2) @(negedge clk);
        check("rst_ctl", ctl, C_IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_h_ready", h_if.ready, 1'b0);
        check("rst_tcam_data", tcam_wr_data, 128'h0);
        h_if.valid = 1'b0;
        rst_n = 1'b1;

        // Host ADD addr 5 and learn DEL addr 15 arrive together: host wins the first tie.
        @(negedge clk);
        h_if.valid = 1'b1; h_if.op = 2'b00; h_if.addr = 4'd5;
        h_if.key = K1; h_if.mask = M1; h_if.action = 64'h1234;
        l_if.valid = 1'b1; l_if.op = 2'b01; l_if.addr = 4'd15;
        l_if.key = K2; l_if.mask = M2; l_if.action = 64'h0;
        #1;
        check("tie_h_ready", h_if.ready, 1'b1);
        check("tie_l_ready", l_if.ready, 1'b0);
        @(posedge clk);
        #1;
        h_if.valid = 1'b0;
        exp_ctl("add_vinv", C_VAL);
        check("add_vinv_addr", tcam_wr_addr, 4'd5);
        check("add_vinv_data", tcam_wr_data, DEL_PAT);
        check("add_busy", busy, 1'b1);
        check("add_l_ready_low", l_if.ready, 1'b0);
        exp_ctl("add_mask", C_MASK);
        check("add_mask_data", tcam_wr_data, M1);
        check("add_mask_addr", tcam_wr_addr, 4'd5);
        exp_ctl("add_act", C_ACT);
        check("add_act_addr", action_wr_addr, 4'd5);
        check("add_act_data", action_wr_data, 64'h1234);
        check("add_act_tcam_zero", tcam_wr_data, 128'h0);
        exp_ctl("add_val", C_VAL);
        check("add_val_data", tcam_wr_data, K1);
        check("add_val_act_zero", action_wr_data, 64'h0);
        exp_ctl("add_done", C_DONEH);
        check("done_l_ready_low", l_if.ready, 1'b0);
        @(negedge clk);
        #1;
        check("l_ready_after_done", l_if.ready, 1'b1);
        check("idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        l_if.valid = 1'b0;
        exp_ctl("del_vinv", C_VAL);
        check("del_vinv_addr", tcam_wr_addr, 4'd15);
        check("del_vinv_data", tcam_wr_data, DEL_PAT);
        exp_ctl("del_mask", C_MASK);
        check("del_mask_addr", tcam_wr_addr, 4'd15);
        check("del_mask_data", tcam_wr_data, {128{1'b1}});
        exp_ctl("del_done", C_DONEL);
        exp_ctl("del_after", C_IDLE);

        // SETDEF: single default pulse at T+1, done at T+2.
        send(1'b0, 2'b10, 4'd0, '0, '0, 64'hDEAD);
        exp_ctl("def_pulse", C_DEF);
        check("def_data", action_default_data, 64'hDEAD);
        check("def_act_data_zero", action_wr_data, 64'h0);
        exp_ctl("def_done", C_DONEH);

        // Illegal op: no writes, error done at T+1.
        send(1'b0, 2'b11, 4'd3, K1, M1, 64'h1);
        exp_ctl("ill_done", C_ERRH);
        exp_ctl("ill_after", C_IDLE);

`ifdef TCAM_PROG_QUIESCE_EN
        // Lookup busy for 10 cycles delays VINV by 10 cycles.
        lookup_active = 1'b1;
        send(1'b0, 2'b00, 4'd7, K2, M2, 64'h77);
        for (int k = 1; k <= 10; k++) begin
            exp_ctl("q_hold", C_IDLE);
            if (k == 10) lookup_active = 1'b0;
        end
        exp_ctl("q_vinv", C_VAL);
        check("q_vinv_addr", tcam_wr_addr, 4'd7);
        exp_ctl("q_mask", C_MASK);
        check("q_mask_data", tcam_wr_data, M2);
        exp_ctl("q_act", C_ACT);
        check("q_act_data", action_wr_data, 64'h77);
        exp_ctl("q_val", C_VAL);
        check("q_val_data", tcam_wr_data, K2);
        exp_ctl("q_done", C_DONEH);

        // Lookup stuck high: each write is forced after 32 stalled cycles.
        lookup_active = 1'b1;
        send(1'b0, 2'b01, 4'd9, '0, '0, '0);
        for (int k = 1; k <= 32; k++) exp_ctl("stuck_hold1", C_IDLE);
        exp_ctl("stuck_vinv", C_VAL);
        check("stuck_vinv_addr", tcam_wr_addr, 4'd9);
        for (int k = 1; k <= 32; k++) exp_ctl("stuck_hold2", C_IDLE);
        exp_ctl("stuck_dmask", C_MASK);
        exp_ctl("stuck_done", C_DONEH);
        lookup_active = 1'b0;
`else
        // Without quiescing, lookup activity has no effect on timing.
        lookup_active = 1'b1;
        send(1'b0, 2'b00, 4'd7, K2, M2, 64'h77);
        exp_ctl("nq_vinv", C_VAL);
        check("nq_vinv_addr", tcam_wr_addr, 4'd7);
        exp_ctl("nq_mask", C_MASK);
        exp_ctl("nq_act", C_ACT);
        check("nq_act_data", action_wr_data, 64'h77);
        exp_ctl("nq_val", C_VAL);
        check("nq_val_data", tcam_wr_data, K2);
        exp_ctl("nq_done", C_DONEH);
        lookup_active = 1'b0;
`endif

        // Reset asserted during ACT: outputs drop at once, no done pulse, new command accepted.
        send(1'b1, 2'b00, 4'd2, K1, M2, 64'hA5A5);
        exp_ctl("rm_vinv", C_VAL);
        exp_ctl("rm_mask", C_MASK);
        exp_ctl("rm_act", C_ACT);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_async_ctl", ctl, C_IDLE);
        check("rm_async_busy", busy, 1'b0);
        check("rm_async_act_data", action_wr_data, 64'h0);
        @(negedge clk);
        check("rm_held_ctl", ctl, C_IDLE);
        rst_n = 1'b1;
        h_if.valid = 1'b1; h_if.op = 2'b10; h_if.action = 64'h55;
        #1;
        check("rm_first_ready", h_if.ready, 1'b1);
        @(posedge clk);
        #1;
        h_if.valid = 1'b0;
        exp_ctl("rm_def", C_DEF);
        check("rm_def_data", action_default_data, 64'h55);
        exp_ctl("rm_done", C_DONEH);
        exp_ctl("rm_after", C_IDLE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
